axi_gpio_responder: RTL

AXI_GPIO_RESPONDER -- requirements
Module: axi_gpio_responder

---
 rtl/gpio_pkg.sv | 39 +++
 rtl/gpio_sync.sv | 25 ++
 rtl/axi_gpio_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants, FSM state type and helpers for the AXI-Lite GPIO responder.
// Register offsets are 12-bit, decoded inside a 4 KiB window.
package gpio_pkg;

    localparam logic [11:0] OFF_DATA_OUT   = 12'h000;
    localparam logic [11:0] OFF_DIR        = 12'h008;
    localparam logic [11:0] OFF_DATA_IN    = 12'h010;
    localparam logic [11:0] OFF_IRQ_EN     = 12'h018;
    localparam logic [11:0] OFF_IRQ_STATUS = 12'h020;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WRESP,
        RRESP
    } state_e;

    function automatic logic is_mapped(input logic [11:0] off);
        return off inside {OFF_DATA_OUT, OFF_DIR, OFF_DATA_IN,
                           OFF_IRQ_EN, OFF_IRQ_STATUS};
    endfunction

    // Byte-lane merge of the low 32 data bits; upper lanes have no register.
    function automatic logic [31:0] merge_strb(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Output follows the input two clock edges later.
module gpio_sync #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;

    // Resolve metastability over two stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/axi_gpio_responder.sv
// AXI-Lite GPIO responder: DATA_OUT/DIR/DATA_IN plus optional edge interrupts.
// Define GPIO_IRQ_EN to build IRQ_EN/IRQ_STATUS and a live irq_o.
module axi_gpio_responder
    import gpio_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int NrGpio    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [63:0]          w_data_i,
    input  logic [7:0]           w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    output logic [63:0]          r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    input  logic [NrGpio-1:0]    gpio_i,
    output logic [NrGpio-1:0]    gpio_o,
    output logic [NrGpio-1:0]    gpio_oe_o,
    output logic                 irq_o
);

    localparam logic [31:0] Mask = (NrGpio >= 32) ? 32'hFFFF_FFFF :
                                   32'((64'd1 << NrGpio) - 64'd1);

    state_e      state;
    logic [31:0] data_out;
    logic [31:0] dir;
    logic [31:0] irq_en_rd;
    logic [31:0] irq_sts_rd;
    logic [NrGpio-1:0] sync_q;
    logic [31:0] data_in;
    logic [11:0] waddr;
    logic [11:0] raddr;
    logic        wr_go;
    logic        rd_go;
    logic [31:0] rd_val;
    logic [31:0] wr_out;
    logic [31:0] wr_dir;
    logic        unused_bits;

    gpio_sync #(
        .Width (NrGpio)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gpio_i),
        .q_o    (sync_q)
    );

    assign data_in = 32'(sync_q);
    assign waddr   = aw_addr_i[11:0];
    assign raddr   = ar_addr_i[11:0];

    // Readys are combinational so a complete pair handshakes the same cycle;
    // held low in reset so nothing is accepted while the FSM is forced.
    assign wr_go = rst_ni && (state == IDLE) && aw_valid_i && w_valid_i;
    assign rd_go = rst_ni && (state == IDLE) && ar_valid_i &&
                   !(aw_valid_i && w_valid_i);

    assign aw_ready_o = wr_go;
    assign w_ready_o  = wr_go;
    assign ar_ready_o = rd_go;

    assign wr_out = merge_strb(data_out, w_data_i[31:0], w_strb_i[3:0]) & Mask;
    assign wr_dir = merge_strb(dir, w_data_i[31:0], w_strb_i[3:0]) & Mask;

    assign gpio_o    = data_out[NrGpio-1:0];
    assign gpio_oe_o = dir[NrGpio-1:0];

    assign unused_bits = ^{aw_addr_i, ar_addr_i, w_data_i[63:32],
                           w_strb_i[7:4], data_out, dir, DataWidth[0]};

    // Read data mux; unmapped offsets return zero
    always_comb begin
        rd_val = '0;
        unique case (raddr)
            OFF_DATA_OUT:   rd_val = data_out;
            OFF_DIR:        rd_val = dir;
            OFF_DATA_IN:    rd_val = data_in;
            OFF_IRQ_EN:     rd_val = irq_en_rd;
            OFF_IRQ_STATUS: rd_val = irq_sts_rd;
            default:        rd_val = '0;
        endcase
    end

    // Output and direction registers, committed at the write handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_out <= '0;
            dir      <= '0;
        end else if (wr_go) begin
            if (waddr == OFF_DATA_OUT) data_out <= wr_out;
            if (waddr == OFF_DIR)      dir      <= wr_dir;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [31:0] irq_en;
    logic [31:0] irq_sts;
    logic [31:0] sync_prev;
    logic [31:0] rise;
    logic [31:0] w1c;
    logic        irq_q;

    assign rise = data_in & ~sync_prev & irq_en;
    assign w1c  = (wr_go && waddr == OFF_IRQ_STATUS) ?
                  (merge_strb('0, w_data_i[31:0], w_strb_i[3:0]) & Mask) :
                  '0;

    // Edge capture; a new edge overrides a clear landing on the same bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en    <= '0;
            irq_sts   <= '0;
            sync_prev <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_prev <= data_in;
            irq_sts   <= (irq_sts & ~w1c) | rise;
            irq_q     <= |irq_sts;
            if (wr_go && waddr == OFF_IRQ_EN) begin
                irq_en <= merge_strb(irq_en, w_data_i[31:0],
                                     w_strb_i[3:0]) & Mask;
            end
        end
    end

    assign irq_en_rd  = irq_en;
    assign irq_sts_rd = irq_sts;
    assign irq_o      = irq_q;
`else
    assign irq_en_rd  = '0;
    assign irq_sts_rd = '0;
    assign irq_o      = 1'b0;
`endif

    // Transaction FSM with registered response channels
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            b_valid_o <= 1'b0;
            b_resp_o  <= OKAY;
            r_valid_o <= 1'b0;
            r_resp_o  <= OKAY;
            r_data_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_go) begin
                        state     <= WRESP;
                        b_valid_o <= 1'b1;
                        b_resp_o  <= is_mapped(waddr) ? OKAY : SLVERR;
                    end else if (rd_go) begin
                        state     <= RRESP;
                        r_valid_o <= 1'b1;
                        r_resp_o  <= is_mapped(raddr) ? OKAY : SLVERR;
                        r_data_o  <= {32'h0, rd_val};
                    end
                end
                WRESP: begin
                    if (b_ready_i) begin
                        state     <= IDLE;
                        b_valid_o <= 1'b0;
                        b_resp_o  <= OKAY;
                    end
                end
                RRESP: begin
                    if (r_ready_i) begin
                        state     <= IDLE;
                        r_valid_o <= 1'b0;
                        r_resp_o  <= OKAY;
                        r_data_o  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
